// File: rtl/spy_pkg.sv
// Shared spy bus definitions: write-side register addresses, CLK/MODE bit
// indices and handshake/single-step state encodings.
package spy_pkg;

  localparam int unsigned SPY_DW = 16;

  localparam int unsigned SPY_W_IRH     = 32'h00;
  localparam int unsigned SPY_W_IRM     = 32'h01;
  localparam int unsigned SPY_W_IRL     = 32'h02;
  localparam int unsigned SPY_W_CLK     = 32'h03;
  localparam int unsigned SPY_W_MODE    = 32'h04;
  localparam int unsigned SPY_W_SCRATCH = 32'h05;
  localparam int unsigned SPY_W_MDH     = 32'h08;
  localparam int unsigned SPY_W_MDL     = 32'h09;
  localparam int unsigned SPY_W_VMAH    = 32'h0A;
  localparam int unsigned SPY_W_VMAL    = 32'h0B;

  localparam int unsigned CLK_RUN  = 0;
  localparam int unsigned CLK_STEP = 1;
  localparam int unsigned CLK_IREN = 2;

  localparam int unsigned MODE_PROMDISABLE = 0;
  localparam int unsigned MODE_ERRSTOP     = 1;
  localparam int unsigned MODE_STATHALT_EN = 2;

  typedef enum logic {IDLE, ACK} hs_state_e;
  typedef enum logic {SS_IDLE, SS_ARMED} ss_state_e;

endpackage

// File: rtl/spy_write_if.sv
// Host-side spy write channel: level request with four-phase acknowledge.
interface spy_write_if #(
  parameter int unsigned AW = 5
) ();
  logic          spy_wr;
  logic [AW-1:0] spy_addr;
  logic [15:0]   spy_in;
  logic          spy_ack;

  modport master (output spy_wr, spy_addr, spy_in, input spy_ack);
  modport slave  (input spy_wr, spy_addr, spy_in, output spy_ack);
endinterface

// File: rtl/spy_sstep.sv
// Single-step sequencer: armed by a CLK step write, completes on the next
// CPU state_write; a concurrent step/clear write takes priority.
module spy_sstep
  import spy_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic step_set_i,
  input  logic step_clr_i,
  input  logic state_write_i,
  output logic armed_o,
  output logic ssdone_o
);

  ss_state_e state_q;
  logic      ssdone_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SS_IDLE;
      ssdone_q <= 1'b0;
    end else if (step_set_i) begin
      state_q  <= SS_ARMED;
      ssdone_q <= 1'b0;
    end else if (step_clr_i) begin
      state_q  <= SS_IDLE;
      ssdone_q <= 1'b0;
    end else if (state_q == SS_ARMED && state_write_i) begin
      state_q  <= SS_IDLE;
      ssdone_q <= 1'b1;
    end
  end

  assign armed_o  = (state_q == SS_ARMED);
  assign ssdone_o = ssdone_q;

endmodule

// File: rtl/spy_write.sv
// Spy bus write decoder: handshake FSM, IR/MD/VMA word assembly, CLK/MODE/
// SCRATCH registers. Single-step sequencer is built when SPY_STEP_EN is defined.
module spy_write
  import spy_pkg::*;
#(
  parameter int unsigned SPY_AW = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  spy_write_if.slave  bus,
  input  logic        state_write,
  output logic [47:0] dbg_ir,
  output logic        dbg_ir_ld,
  output logic [31:0] spy_ld_data,
  output logic        md_ld,
  output logic        vma_ld,
  output logic        dbg_ir_en,
  output logic [7:0]  mode,
  output logic [15:0] scratch,
  output logic        srun,
  output logic        ssdone
);

  hs_state_e   hs_q;
  logic        spy_ack_q;
  logic [15:0] ir_hi_q, ir_mid_q, ld_hi_q;
  logic [47:0] dbg_ir_q;
  logic [31:0] ld_data_q;
  logic        dbg_ir_ld_q, md_ld_q, vma_ld_q;
  logic        run_q, dbg_ir_en_q;
  logic [7:0]  mode_q;
  logic [15:0] scratch_q;
  logic        wr_fire_c;
  logic        clk_wr_c;
  logic        armed;

  // A write is performed only on the IDLE->ACK transition, so one per request.
  assign wr_fire_c = (hs_q == IDLE) && bus.spy_wr;
  assign clk_wr_c  = wr_fire_c && (bus.spy_addr == SPY_AW'(SPY_W_CLK));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q        <= IDLE;
      spy_ack_q   <= 1'b0;
      ir_hi_q     <= '0;
      ir_mid_q    <= '0;
      ld_hi_q     <= '0;
      dbg_ir_q    <= '0;
      ld_data_q   <= '0;
      dbg_ir_ld_q <= 1'b0;
      md_ld_q     <= 1'b0;
      vma_ld_q    <= 1'b0;
      run_q       <= 1'b0;
      dbg_ir_en_q <= 1'b0;
      mode_q      <= '0;
      scratch_q   <= '0;
    end else begin
      dbg_ir_ld_q <= 1'b0;
      md_ld_q     <= 1'b0;
      vma_ld_q    <= 1'b0;

      case (hs_q)
        IDLE: if (bus.spy_wr) begin
          hs_q      <= ACK;
          spy_ack_q <= 1'b1;
        end
        ACK: if (!bus.spy_wr) begin
          hs_q      <= IDLE;
          spy_ack_q <= 1'b0;
        end
        default: begin
          hs_q      <= IDLE;
          spy_ack_q <= 1'b0;
        end
      endcase

      if (wr_fire_c) begin
        case (bus.spy_addr)
          SPY_AW'(SPY_W_IRH):     ir_hi_q  <= bus.spy_in;
          SPY_AW'(SPY_W_IRM):     ir_mid_q <= bus.spy_in;
          SPY_AW'(SPY_W_IRL): begin
            dbg_ir_q    <= {ir_hi_q, ir_mid_q, bus.spy_in};
            dbg_ir_ld_q <= 1'b1;
          end
          SPY_AW'(SPY_W_CLK): begin
            run_q       <= bus.spy_in[CLK_RUN];
            dbg_ir_en_q <= bus.spy_in[CLK_IREN];
          end
          SPY_AW'(SPY_W_MODE):    mode_q    <= bus.spy_in[7:0];
          SPY_AW'(SPY_W_SCRATCH): scratch_q <= bus.spy_in;
          SPY_AW'(SPY_W_MDH),
          SPY_AW'(SPY_W_VMAH):    ld_hi_q   <= bus.spy_in;
          SPY_AW'(SPY_W_MDL): begin
            ld_data_q <= {ld_hi_q, bus.spy_in};
            md_ld_q   <= 1'b1;
          end
          SPY_AW'(SPY_W_VMAL): begin
            ld_data_q <= {ld_hi_q, bus.spy_in};
            vma_ld_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPY_STEP_EN
  spy_sstep u_sstep (
    .clk           (clk),
    .reset_n       (reset_n),
    .step_set_i    (clk_wr_c && bus.spy_in[CLK_STEP]),
    .step_clr_i    (clk_wr_c && !bus.spy_in[CLK_STEP]),
    .state_write_i (state_write),
    .armed_o       (armed),
    .ssdone_o      (ssdone)
  );
`else
  logic unused_step;
  assign unused_step = state_write ^ clk_wr_c;
  assign armed       = 1'b0;
  assign ssdone      = 1'b0;
`endif

  assign bus.spy_ack  = spy_ack_q;
  assign dbg_ir       = dbg_ir_q;
  assign dbg_ir_ld    = dbg_ir_ld_q;
  assign spy_ld_data  = ld_data_q;
  assign md_ld        = md_ld_q;
  assign vma_ld       = vma_ld_q;
  assign dbg_ir_en    = dbg_ir_en_q;
  assign mode         = mode_q;
  assign scratch      = scratch_q;
  assign srun         = run_q | armed;

endmodule

// File: tb/tb_spy_write.sv
// Self-checking bench for spy_write: directed scenarios plus random host
// writes, checked against a register-level model of the spy write map.
module tb_spy_write;
  import spy_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        state_write = 1'b0;
  logic [47:0] dbg_ir;
  logic        dbg_ir_ld;
  logic [31:0] spy_ld_data;
  logic        md_ld, vma_ld, dbg_ir_en, srun, ssdone;
  logic [7:0]  mode;
  logic [15:0] scratch;

  spy_write_if #(.AW(5)) bus ();

  spy_write #(.SPY_AW(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .state_write (state_write),
    .dbg_ir      (dbg_ir),
    .dbg_ir_ld   (dbg_ir_ld),
    .spy_ld_data (spy_ld_data),
    .md_ld       (md_ld),
    .vma_ld      (vma_ld),
    .dbg_ir_en   (dbg_ir_en),
    .mode        (mode),
    .scratch     (scratch),
    .srun        (srun),
    .ssdone      (ssdone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_ir = 0, n_md = 0, n_vma = 0;

  // reference model state
  logic [15:0] m_ir_hi, m_ir_mid, m_ld_hi, m_scratch;
  logic [47:0] m_dbg_ir;
  logic [31:0] m_ld;
  logic [7:0]  m_mode;
  logic        m_run, m_iren, m_armed, m_ssdone;
  int          e_ir, e_md, e_vma;

  always @(negedge clk) begin
    if (dbg_ir_ld) n_ir++;
    if (md_ld) n_md++;
    if (vma_ld) n_vma++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ir_hi = '0; m_ir_mid = '0; m_ld_hi = '0; m_scratch = '0;
    m_dbg_ir = '0; m_ld = '0; m_mode = '0;
    m_run = 0; m_iren = 0; m_armed = 0; m_ssdone = 0;
  endtask

  task automatic model_sw();
    if (m_armed) begin
      m_armed  = 0;
      m_ssdone = 1;
    end
  endtask

  task automatic model_write(input int a, input logic [15:0] d, input bit sw);
    e_ir = 0; e_md = 0; e_vma = 0;
    if (sw && a != 3) model_sw();
    case (a)
      0: m_ir_hi = d;
      1: m_ir_mid = d;
      2: begin m_dbg_ir = {m_ir_hi, m_ir_mid, d}; e_ir = 1; end
      3: begin
        m_run  = d[0];
        m_iren = d[2];
`ifdef SPY_STEP_EN
        m_armed  = d[1];
        m_ssdone = 0;
`endif
      end
      4: m_mode = d[7:0];
      5: m_scratch = d;
      8, 10: m_ld_hi = d;
      9:  begin m_ld = {m_ld_hi, d}; e_md = 1; end
      11: begin m_ld = {m_ld_hi, d}; e_vma = 1; end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dbg_ir"}, dbg_ir, m_dbg_ir);
    check({tag, ".ld_data"}, spy_ld_data, m_ld);
    check({tag, ".mode"}, mode, m_mode);
    check({tag, ".scratch"}, scratch, m_scratch);
    check({tag, ".ir_en"}, dbg_ir_en, m_iren);
    check({tag, ".srun"}, srun, m_run | m_armed);
    check({tag, ".ssdone"}, ssdone, m_ssdone);
  endtask

  task automatic host_wr(input int a, input logic [15:0] d, input int hold, input bit sw);
    int n;
    n_ir = 0; n_md = 0; n_vma = 0;
    @(negedge clk);
    bus.spy_addr = 5'(a);
    bus.spy_in   = d;
    bus.spy_wr   = 1'b1;
    state_write  = sw;
    @(negedge clk);
    state_write = 1'b0;
    check("ack_rise", bus.spy_ack, 1);
    model_write(a, d, sw);
    repeat (hold - 1) @(negedge clk);
    check("ack_hold", bus.spy_ack, 1);
    bus.spy_wr = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.spy_ack && n < 4);
    check("ack_fall_lat", n, 1);
    check("ack_low", bus.spy_ack, 0);
    check("ir_ld_cnt", n_ir, e_ir);
    check("md_ld_cnt", n_md, e_md);
    check("vma_ld_cnt", n_vma, e_vma);
    check_all($sformatf("wr%0h", a));
  endtask

  task automatic pulse_sw();
    @(negedge clk);
    state_write = 1'b1;
    @(negedge clk);
    state_write = 1'b0;
    model_sw();
    check_all("sw");
  endtask

  int addrs[12] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 7, 30};

  initial begin
    bus.spy_wr = 1'b0;
    bus.spy_addr = '0;
    bus.spy_in = '0;
    model_reset();
    #1;
    check("rst_ack", bus.spy_ack, 0);
    check("rst_pulses", {dbg_ir_ld, md_ld, vma_ld}, 0);
    check_all("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // IR assembly
    host_wr(0, 16'h1234, 1, 0);
    host_wr(1, 16'h5678, 1, 0);
    host_wr(2, 16'h9ABC, 1, 0);
    check("ir_value", dbg_ir, 48'h123456789ABC);
    host_wr(2, 16'h0001, 1, 0);

    // MD load
    host_wr(8, 16'hDEAD, 1, 0);
    host_wr(9, 16'hBEEF, 1, 0);
    check("md_value", spy_ld_data, 32'hDEADBEEF);

    // long hold: single action
    host_wr(5, 16'h00FF, 10, 0);
    host_wr(2, 16'hCAFE, 10, 0);

    // single step
    host_wr(3, 16'h0002, 1, 0);
    pulse_sw();
    pulse_sw();
    host_wr(3, 16'h0000, 1, 0);
    // step write colliding with state_write: write wins
    host_wr(3, 16'h0002, 1, 1);
    pulse_sw();
    // step with run set
    host_wr(3, 16'h0003, 2, 0);
    pulse_sw();

    // unmapped address
    host_wr(31, 16'hFFFF, 1, 0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      int a;
      a = addrs[$urandom_range(0, 11)];
      host_wr(a, 16'($urandom), $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) pulse_sw();
    end

    // reset mid-transaction with request still held
    host_wr(3, 16'h0005, 1, 0);
    host_wr(4, 16'h0007, 1, 0);
    @(negedge clk);
    bus.spy_addr = 5'(5);
    bus.spy_in   = 16'hA5A5;
    bus.spy_wr   = 1'b1;
    @(negedge clk);
    model_write(5, 16'hA5A5, 0);
    check("pre_rst_ack", bus.spy_ack, 1);
    check("pre_rst_srun", srun, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ack", bus.spy_ack, 0);
    check("arst_mode", mode, 0);
    check("arst_scratch", scratch, 0);
    check("arst_srun", srun, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reserv_ack", bus.spy_ack, 1);
    model_write(5, 16'hA5A5, 0);
    check_all("reserv");
    bus.spy_wr = 1'b0;
    @(negedge clk);
    check("reserv_fall", bus.spy_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spy_write.md
# spy_write

Host-side write decoder for the spy (PDP11 debug) bus, and the counterpart of the spy read mux. It accepts 16-bit writes from the debug host over a four-phase req/ack handshake and decodes the spy address. It assembles the 48-bit debug IR and the 32-bit MD/VMA load words from 16-bit halves. It holds the clock-control, mode and scratch registers, and runs the single-step sequencer that produces `srun`/`ssdone` for the CPU and the spy read mux.

## Interface

Parameters:
- `SPY_AW`, 5: spy address width.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `spy_wr`  in  1: host write request; a level held until `spy_ack`.
- `spy_addr`  in  SPY_AW: register select; stable while `spy_wr` is high.
- `spy_in`  in  16: write data; stable while `spy_wr` is high.
- `spy_ack`  out  1: write acknowledge.
- `state_write`  in  1: CPU cycle-boundary strobe, one cycle wide.
- `dbg_ir`  out  48: assembled debug IR.
- `dbg_ir_ld`  out  1: one-cycle pulse when `dbg_ir` is committed.
- `spy_ld_data`  out  32: MD/VMA load word.
- `md_ld`  out  1: one-cycle pulse loading MD from `spy_ld_data`.
- `vma_ld`  out  1: one-cycle pulse loading VMA from `spy_ld_data`.
- `dbg_ir_en`  out  1: CPU takes IR from `dbg_ir` instead of IRAM.
- `mode`  out  8: mode register (bit0 `promdisable`, bit1 `errstop`, bit2 `stathalt_en`, the rest spare).
- `scratch`  out  16: scratch register.
- `srun`  out  1: machine run enable.
- `ssdone`  out  1: single step completed.

## Operation

Address map (`spy_addr`):
- 0x00 IRH → staging `ir_hi[47:32]`
- 0x01 IRM → staging `ir_mid[31:16]`
- 0x02 IRL → `dbg_ir <= {ir_hi, ir_mid, spy_in}`; pulses `dbg_ir_ld`
- 0x03 CLK → bit0 `run`, bit1 `step`, bit2 `dbg_ir_en`
- 0x04 MODE → `mode <= spy_in[7:0]`
- 0x05 SCRATCH → `scratch <= spy_in`
- 0x08 MDH → staging `ld_hi`
- 0x09 MDL → `spy_ld_data <= {ld_hi, spy_in}`; pulses `md_ld`
- 0x0A VMAH → staging `ld_hi`, the same register as MDH
- 0x0B VMAL → `spy_ld_data <= {ld_hi, spy_in}`; pulses `vma_ld`
- Any other address is acknowledged and has no effect.

Handshake FSM:
- `IDLE`: when `spy_wr=1`, perform the decoded write, go to `ACK` and set `spy_ack=1`.
- `ACK`: hold `spy_ack=1` while `spy_wr=1`. When `spy_wr=0`, go to `IDLE` and clear `spy_ack` on the next edge.
- Exactly one write action is performed per request, however long `spy_wr` is held.

Single-step FSM (`SS_IDLE`, `SS_ARMED`):
- A CLK write with `step=1` clears `ssdone` and enters `SS_ARMED`.
- In `SS_ARMED`, the first `state_write` returns to `SS_IDLE` and sets `ssdone=1` at that edge.
- A CLK write with `step=0` clears `ssdone` and forces `SS_IDLE`.
- `srun = run | (state == SS_ARMED)`. With `run=1` the step still completes on the next `state_write`.
- The `step` bit is not stored; it acts only on the write.

Staging registers hold their value after a commit. A bare IRL write reuses the previous IRH/IRM halves.

## Timing

- Reset values are 0 for every output and internal register. FSMs reset to `IDLE`/`SS_IDLE`.
- Write action and `spy_ack` rise take effect at the same edge: the first edge that samples `spy_wr=1` in `IDLE`.
- `dbg_ir_ld`, `md_ld` and `vma_ld` are high for exactly that one cycle. The data they qualify is valid from the same edge.
- `spy_ack` falls one edge after `spy_wr` is sampled low, so the minimum transaction is 2 cycles.
- If a CLK step write and `state_write` occur in the same cycle, the write wins: the FSM enters `SS_ARMED` and that `state_write` is ignored.
- Asserting `reset_n` mid-transaction drops `spy_ack` immediately. If the host is still holding `spy_wr` after release, the request is re-serviced.

## Configuration

- `SPY_STEP_EN` defined: single-step FSM present, as described above.
- Undefined: the `step` bit is ignored, `ssdone` is tied 0 and `srun = run`.

## Structure

- Shared package `spy_pkg` holds:
  - the spy address localparams (`SPY_W_IRH` … `SPY_W_VMAL`), also used by the read side;
  - the CLK bit indices;
  - the mode bit indices.
- One sub-module, `spy_sstep`: the single-step FSM. Inputs are the step/clear strobes and `state_write`; outputs are `armed` and `ssdone`.

## Test plan

- Write 0x00=0x1234, 0x01=0x5678, 0x02=0x9ABC → `dbg_ir`=0x123456789ABC; `dbg_ir_ld` high exactly one cycle.
- Write 0x08=0xDEAD, 0x09=0xBEEF → `spy_ld_data`=0xDEADBEEF; `md_ld` one pulse; `vma_ld` stays 0.
- Hold `spy_wr` for 10 cycles writing 0x05=0x00FF → `scratch`=0x00FF; one action only; `spy_ack` high until one edge after `spy_wr` falls.
- Write CLK=0x0002, then pulse `state_write` twice → `srun` high only until the first pulse; `ssdone`=1 after it and remains 1; the next CLK write of 0x0000 clears it.
- Write 0x1F=0xFFFF → acknowledged; all outputs unchanged.
- Drop `reset_n` while in `ACK` → `spy_ack`, `mode`, `scratch` and `srun` all 0 asynchronously.
